// File: rtl/sort_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : sort_result_collector
// Brief   : Captures one sorter result frame, drops pad words, checks float
//           ordering of retained words and streams them out with backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module sort_result_collector #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] PAD_VALUE = 32'h7F7F_FFFF
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   order_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [IW-1:0] c_idx_one  = IW'(1);
  localparam logic [IW-1:0] c_idx_last = IW'(DEPTH - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [CW-1:0] c_cnt_two  = CW'(2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_widx;
  logic [IW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_buf [DEPTH];

  logic             w_take;
  logic             w_keep;
  logic             w_final;
  logic             w_xfer;
  logic             w_lt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [IW-1:0]    w_rptr_inc;

  // Float "a < b": sign-magnitude order, signed zeros equal, NaNs as raw bits.
  function automatic logic f_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-2:0] ma;
    logic [WIDTH-2:0] mb;
    ma = a[WIDTH-2:0];
    mb = b[WIDTH-2:0];
    if (ma == '0 && mb == '0)
      f_less = 1'b0;
    else if (a[WIDTH-1] != b[WIDTH-1])
      f_less = a[WIDTH-1];
    else if (a[WIDTH-1])
      f_less = (ma > mb);
    else
      f_less = (ma < mb);
  endfunction

  assign w_take     = (r_state == ST_CAPTURE) && in_valid;
  assign w_keep     = w_take && (in_data != PAD_VALUE);
  assign w_final    = w_take && (r_widx == c_idx_last);
  assign w_xfer     = (r_state == ST_DRAIN) && out_valid && out_ready;
  assign w_lt       = f_less(in_data, r_prev);
  assign w_cnt_nxt  = w_keep ? (count + c_cnt_one) : count;
  assign w_rptr_inc = r_rptr + c_idx_one;

  always_ff @(posedge clk) begin
    if (w_keep)
      r_buf[count[IW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state   <= ST_IDLE;
      r_widx    <= '0;
      r_rptr    <= '0;
      r_prev    <= '0;
      count     <= '0;
      order_err <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_CAPTURE;
            busy      <= 1'b1;
            r_widx    <= '0;
            r_rptr    <= '0;
            count     <= '0;
            order_err <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (w_take) begin
            r_widx <= r_widx + c_idx_one;
            if (w_keep) begin
              count  <= w_cnt_nxt;
              r_prev <= in_data;
              if (count != '0 && w_lt)
                order_err <= 1'b1;
            end
            if (w_final) begin
              if (w_cnt_nxt != '0) begin
                r_state   <= ST_DRAIN;
                out_valid <= 1'b1;
                out_last  <= (w_cnt_nxt == c_cnt_one);
                // Word 0 may be the one being written on this very edge.
                out_data  <= (count == '0) ? in_data : r_buf[0];
              end else begin
                r_state <= ST_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_xfer) begin
            r_rptr <= w_rptr_inc;
            if (out_last) begin
              r_state   <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_data <= r_buf[w_rptr_inc];
              out_last <= (({1'b0, r_rptr} + c_cnt_two) == count);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sort_result_collector.md
SORT_RESULT_COLLECTOR -- requirements
Module: sort_result_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the word width (IEEE-754 single precision).
REQ-002 The block SHALL have parameter DEPTH, default 16, the number of words in one sorter result frame.
REQ-003 The block SHALL have parameter PAD_VALUE, default 32'h7F7F_FFFF, the padding word that the sorter emits for empty slots.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 res  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that arms capture of a new frame.
REQ-007 in_valid  input  1  in_data carries a sorter output word this cycle.
REQ-008 in_data  input  WIDTH  sorter output word.
REQ-009 out_valid  output  1  out_data holds a retained word.
REQ-010 out_data  output  WIDTH  retained word, in capture order.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_last  output  1  out_data is the final retained word of the frame.
REQ-013 busy  output  1  high in CAPTURE and DRAIN.
REQ-014 done  output  1  one-cycle pulse at frame completion.
REQ-015 count  output  $clog2(DEPTH)+1  number of retained (non-pad) words in the current frame.
REQ-016 order_err  output  1  sticky flag: a retained word was less than its predecessor.

Function
REQ-017 The FSM SHALL have states IDLE, CAPTURE and DRAIN.
REQ-018 In IDLE, start SHALL move the FSM to CAPTURE on the next edge and clear the word index, count, read pointer and order_err.
REQ-019 start SHALL be ignored in CAPTURE and DRAIN; in_valid SHALL be ignored in IDLE and DRAIN.
REQ-020 In CAPTURE, each cycle with in_valid=1 SHALL consume one word and increment the word index (0..DEPTH-1).
REQ-021 A consumed word not equal to PAD_VALUE SHALL be written to buffer[count], and count SHALL increment on the same edge.
REQ-022 A consumed word equal to PAD_VALUE SHALL be discarded, and count SHALL be unchanged.
REQ-023 On each retained word after the first, order_err SHALL be set if new < previous retained word under the float order in REQ-024; order_err SHALL remain set until the next start or reset.
REQ-024 Float order definition:
- both positive: compare magnitudes ascending;
- both negative: larger magnitude is smaller;
- differing signs: the negative word is smaller;
- -0 and +0 are equal, with no error in either order;
- NaN patterns are compared as ordinary bit patterns.
REQ-025 When the DEPTH-th word is consumed, the FSM SHALL go to DRAIN if count (including that word) > 0.
REQ-026 If count = 0 when the DEPTH-th word is consumed, the FSM SHALL go to IDLE and pulse done on the next cycle.
REQ-027 In DRAIN:
- out_valid=1 and out_data=buffer[rptr];
- a transfer occurs on out_valid & out_ready, which increments rptr;
- out_data SHALL hold stable while out_ready=0.
REQ-028 out_last SHALL be 1 only in DRAIN with rptr = count-1.
REQ-029 The transfer with out_last=1 SHALL return the FSM to IDLE, and done SHALL be 1 for the following single cycle.
REQ-030 out_valid SHALL rise on the first clock after the edge that consumes the DEPTH-th word.
REQ-031 Minimum frame latency from start to done SHALL be DEPTH+count+1 cycles.
REQ-032 count and order_err SHALL hold their final values in IDLE until the next start.

Reset
REQ-033 While res=0, regardless of clock, the block SHALL force:
- FSM = IDLE;
- out_valid, out_last, busy, done, order_err = 0;
- count, rptr, word index = 0;
- out_data = 0.
REQ-034 Reset asserted mid-CAPTURE or mid-DRAIN SHALL abandon the frame, with no done pulse.
REQ-035 Buffer contents need not be reset.

Verification
REQ-036 Sorted frame: start, then C0400000, BDB851EC, 3F000000, 408B851F, 40C00000, 41100000, 41300000, followed by 9 x 7F7FFFFF with out_ready=1 -> count=7, order_err=0, those 7 words out in order, out_last on 41300000, one done pulse.
REQ-037 Unsorted frame: 41300000 before 41100000, rest as REQ-036 -> order_err=1 and stays 1 after done.
REQ-038 All-pad frame: 16 x 7F7FFFFF -> count=0, out_valid never 1, done pulse one cycle after the 16th word.
REQ-039 Backpressure: out_ready=0 for 5 cycles in DRAIN -> out_data and out_valid held, rptr unchanged; the stream resumes without loss.
REQ-040 Signed zero and gaps: 80000000 then 00000000 with in_valid gaps -> count=2, order_err=0, gaps do not advance the word index.
REQ-041 Reset mid-CAPTURE after 5 words, then a new start -> all outputs per REQ-033, and the next frame is captured correctly from word 0.
